// File: rtl/note_sequencer_if.sv
// CPU-side write bus and Sound-side outputs of the note sequencer.
// The master modport is the CPU/bench side; the slave modport is the sequencer.
interface note_sequencer_if;
    logic        load;
    logic        addr;
    logic [15:0] in;
    logic        stop;
    logic [15:0] out;
    logic        busy;
    logic        full;
    logic        empty;
    logic        ovf;

    modport master (
        output load, addr, in, stop,
        input  out, busy, full, empty, ovf
    );

    modport slave (
        input  load, addr, in, stop,
        output out, busy, full, empty, ovf
    );
endinterface

// File: rtl/note_sequencer.sv
// Tone queue feeding Sound: the CPU pushes {period, duration} notes into a FIFO,
// and each note holds its period on out for duration ticks, back-to-back.
module note_sequencer #(
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 25000
) (
    input  logic             clk,
    input  logic             reset,
    note_sequencer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {IDLE, PLAY} state_t;

    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  wptr, rptr;
    logic [CW-1:0]  count;
    logic           empty_r, full_r, ovf_r;
    logic [15:0]    period_reg;

    state_t         state, state_n;
    logic [15:0]    out_r, out_n;
    logic [15:0]    rem, rem_n;
    logic [TW-1:0]  tick, tick_n;
    logic           pop;

    logic           push_req, push_ok, full_now, have_note;
    logic [15:0]    head_period, head_dur;

    assign push_req    = bus.load & bus.addr & ~bus.stop;
    assign full_now    = (count == CW'(DEPTH));
    assign push_ok     = push_req & ~full_now;
    // The empty flag lags count by one edge; the count test keeps a stale flag
    // from popping an entry that was just consumed.
    assign have_note   = ~empty_r & (count != '0);
    assign head_period = mem[rptr][31:16];
    assign head_dur    = mem[rptr][15:0];

    assign bus.out   = out_r;
    assign bus.busy  = (state == PLAY);
    assign bus.full  = full_r;
    assign bus.empty = empty_r;
    assign bus.ovf   = ovf_r;

    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wptr] <= {period_reg, bus.in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            ovf_r      <= 1'b0;
            period_reg <= '0;
        end else if (bus.stop) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            if (bus.load && !bus.addr) begin
                period_reg <= bus.in;
            end
            if (push_req && full_now) begin
                ovf_r <= 1'b1;
            end
            if (push_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            empty_r <= (count == '0);
            full_r  <= full_now;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.stop) begin
            state <= IDLE;
            out_r <= '0;
            rem   <= '0;
            tick  <= '0;
        end else begin
            state <= state_n;
            out_r <= out_n;
            rem   <= rem_n;
            tick  <= tick_n;
        end
    end

    always_comb begin
        state_n = state;
        out_n   = out_r;
        rem_n   = rem;
        tick_n  = tick;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                out_n = '0;
                if (have_note) begin
                    pop   = 1'b1;
                    rem_n = head_dur;
                    tick_n = '0;
                    if (head_dur != '0) begin
                        state_n = PLAY;
                        out_n   = head_period;
                    end
                end
            end
            PLAY: begin
                if (tick == TW'(TICK_DIV - 1)) begin
                    tick_n = '0;
                    if (rem == 16'd1) begin
                        // Note end: chain straight into the next note when one is queued.
                        if (have_note) begin
                            pop   = 1'b1;
                            rem_n = head_dur;
                            if (head_dur == '0) begin
                                state_n = IDLE;
                                out_n   = '0;
                            end else begin
                                out_n = head_period;
                            end
                        end else begin
                            state_n = IDLE;
                            out_n   = '0;
                            rem_n   = '0;
                        end
                    end else begin
                        rem_n = rem - 16'd1;
                    end
                end else begin
                    tick_n = tick + TW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                out_n   = '0;
            end
        endcase
    end
endmodule
